// File: rtl/stopwatch_ctrl_if.sv
// Key inputs and counter/display controls of the stopwatch sequencer.
//   KEY_SS, KEY_CL : raw active-low push keys (0 = pressed), asynchronous
//   TICK           : 1-cycle count enable to the seconds counter
//   CLR            : 1-cycle synchronous clear to the seconds counter
//   FREEZE         : level, display latch holds its value while 1
//   RUN_LED        : 1 while the stopwatch is counting (RUN or LAP)
// master = key source / counter side, slave = stopwatch_ctrl.
interface stopwatch_ctrl_if;
  logic KEY_SS;
  logic KEY_CL;
  logic TICK;
  logic CLR;
  logic FREEZE;
  logic RUN_LED;

  modport master (output KEY_SS, KEY_CL, input TICK, CLR, FREEZE, RUN_LED);
  modport slave  (input KEY_SS, KEY_CL, output TICK, CLR, FREEZE, RUN_LED);
endinterface

// File: rtl/stopwatch_ctrl.sv
// Control sequencer for the 00-59 s counter / 7-segment display datapath.
// Debounces the start/stop and clear/lap keys, runs the IDLE/RUN/PAUSE/LAP
// state machine and generates the counter enable, clear and display freeze.
// Ports:
//   CLK : system clock
//   RST : synchronous, active-high reset
//   bus : stopwatch_ctrl_if.slave (KEY_SS, KEY_CL in; TICK, CLR, FREEZE, RUN_LED out)
// Parameters:
//   DIV        : CLK cycles per TICK (>= 2)
//   DEB_CYCLES : consecutive stable cycles needed to accept a key level (>= 1)
module stopwatch_ctrl #(
  parameter int unsigned DIV        = 50_000_000,
  parameter int unsigned DEB_CYCLES = 1_000_000
) (
  input  logic             CLK,
  input  logic             RST,
  stopwatch_ctrl_if.slave  bus
);

  localparam int unsigned PW = $clog2(DIV);
  localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, LAP} state_t;

  // Index 0 = start/stop key, index 1 = clear/lap key.
  logic [1:0]         sync_1, sync_2;
  logic [1:0]         deb, deb_d;
  logic [1:0]         press;
  logic [1:0][CW-1:0] deb_cnt;

  state_t        state;
  logic [PW-1:0] presc;
  logic          clr_q, freeze_q, led_q;

  logic ss_p, cl_p, counting;

  assign ss_p     = press[0];
  assign cl_p     = press[1];
  assign counting = (state == RUN) || (state == LAP);

  // ---------------------------------------------------------------------------
  // Key path: 2-FF synchronizer, debounce counter, registered falling-edge
  // detector. A clean raw edge yields a press pulse 2 + DEB_CYCLES + 1 cycles
  // later.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_1  <= 2'b11;
      sync_2  <= 2'b11;
      deb     <= 2'b11;
      deb_d   <= 2'b11;
      press   <= 2'b00;
      deb_cnt <= '0;
    end else begin
      // NOTE: every register here is assigned with <= so all of them sample
      // the pre-edge values; a blocking = would collapse the synchronizer.
      sync_1 <= {bus.KEY_CL, bus.KEY_SS};
      sync_2 <= sync_1;
      deb_d  <= deb;
      press  <= deb_d & ~deb;
      for (int k = 0; k < 2; k++) begin
        if (sync_2[k] != deb[k]) begin
          if (deb_cnt[k] == CW'(DEB_CYCLES - 1)) begin
            deb[k]     <= sync_2[k];
            deb_cnt[k] <= '0;
          end else begin
            deb_cnt[k] <= deb_cnt[k] + 1'b1;
          end
        end else begin
          // Bounce back to the accepted level restarts the stability window.
          deb_cnt[k] <= '0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State machine with registered outputs and the TICK prescaler.
  // Start/stop has priority: when both pulses coincide, clear/lap is dropped.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      presc    <= '0;
      clr_q    <= 1'b0;
      freeze_q <= 1'b0;
      led_q    <= 1'b0;
    end else begin
      clr_q <= 1'b0;

      // Prescaler advances in the counting states and holds in PAUSE so a
      // resumed run keeps its sub-second phase.
      if (counting) begin
        presc <= (presc == PW'(DIV - 1)) ? '0 : presc + 1'b1;
      end

      case (state)
        IDLE: begin
          if (ss_p) begin
            state <= RUN;
            led_q <= 1'b1;
          end else if (cl_p) begin
            clr_q <= 1'b1;
          end
        end
        RUN: begin
          if (ss_p) begin
            state <= PAUSE;
            led_q <= 1'b0;
          end else if (cl_p) begin
            state    <= LAP;
            freeze_q <= 1'b1;
          end
        end
        LAP: begin
          if (ss_p) begin
            state    <= PAUSE;
            freeze_q <= 1'b0;
            led_q    <= 1'b0;
          end else if (cl_p) begin
            state    <= RUN;
            freeze_q <= 1'b0;
          end
        end
        PAUSE: begin
          if (ss_p) begin
            state <= RUN;
            led_q <= 1'b1;
          end else if (cl_p) begin
            state <= IDLE;
            presc <= '0;
            clr_q <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          freeze_q <= 1'b0;
          led_q    <= 1'b0;
        end
      endcase
    end
  end

  // TICK is combinational so it lines up with the prescaler terminal count;
  // a TICK in the same cycle as a start/stop pulse is still delivered.
  assign bus.TICK    = counting && (presc == PW'(DIV - 1));
  assign bus.CLR     = clr_q;
  assign bus.FREEZE  = freeze_q;
  assign bus.RUN_LED = led_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with DIV=10, DEB_CYCLES=4.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_stopwatch_ctrl;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  stopwatch_ctrl_if sw_if ();

  stopwatch_ctrl #(.DIV(10), .DEB_CYCLES(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (sw_if)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Press the selected key(s) for 8 cycles. With DEB_CYCLES=4 the state
  // changes on the 8th edge after the raw edge; samples are taken just before
  // (cycle 7) and just after (cycle 8) that edge. Keys are released on return.
  task automatic press(input logic ss, input logic cl,
                       output int led7, output int led8, output int frz8,
                       output int clr7, output int clr8);
    if (ss) sw_if.KEY_SS = 1'b0;
    if (cl) sw_if.KEY_CL = 1'b0;
    repeat (7) step();
    led7 = sw_if.RUN_LED;
    clr7 = sw_if.CLR;
    step();
    led8 = sw_if.RUN_LED;
    frz8 = sw_if.FREEZE;
    clr8 = sw_if.CLR;
    sw_if.KEY_SS = 1'b1;
    sw_if.KEY_CL = 1'b1;
  endtask

  // Observe n cycles; index 1 is the first cycle after the call.
  task automatic window(input int n, output int first, output int n_tick,
                        output int n_clr, output int n_led, output int n_frz);
    first = -1; n_tick = 0; n_clr = 0; n_led = 0; n_frz = 0;
    for (int i = 1; i <= n; i++) begin
      step();
      if (sw_if.TICK) begin
        n_tick++;
        if (first < 0) first = i;
      end
      if (sw_if.CLR)     n_clr++;
      if (sw_if.RUN_LED) n_led++;
      if (sw_if.FREEZE)  n_frz++;
    end
  endtask

  initial begin
    int led7, led8, frz8, clr7, clr8;
    int first, n_tick, n_clr, n_led, n_frz;
    int changes, prev_led;

    sw_if.KEY_SS = 1'b1;
    sw_if.KEY_CL = 1'b1;
    repeat (3) step();
    RST = 1'b0;

    // Reset state
    check("rst_tick", sw_if.TICK, 0);
    check("rst_clr", sw_if.CLR, 0);
    check("rst_freeze", sw_if.FREEZE, 0);
    check("rst_led", sw_if.RUN_LED, 0);

    // No keys for 100 cycles: everything quiet
    window(100, first, n_tick, n_clr, n_led, n_frz);
    check("idle_ticks", n_tick, 0);
    check("idle_clr", n_clr, 0);
    check("idle_led", n_led, 0);
    check("idle_freeze", n_frz, 0);

    // CL in IDLE: one CLR pulse, stays IDLE
    press(1'b0, 1'b1, led7, led8, frz8, clr7, clr8);
    check("idle_cl_clr_before", clr7, 0);
    check("idle_cl_clr", clr8, 1);
    check("idle_cl_led", led8, 0);
    window(10, first, n_tick, n_clr, n_led, n_frz);
    check("idle_cl_clr_once", n_clr, 0);

    // SS: IDLE -> RUN 8 cycles after the raw edge, first TICK on 10th cycle
    press(1'b1, 1'b0, led7, led8, frz8, clr7, clr8);
    check("start_led_early", led7, 0);
    check("start_led", led8, 1);
    check("start_clr", clr8, 0);
    window(17, first, n_tick, n_clr, n_led, n_frz);
    check("run_first_tick", first, 9);
    check("run_ticks17", n_tick, 1);

    // State changes 25 cycles after RUN was entered -> prescaler holds 5
    press(1'b1, 1'b0, led7, led8, frz8, clr7, clr8);
    check("pause_led_early", led7, 1);
    check("pause_led", led8, 0);
    window(20, first, n_tick, n_clr, n_led, n_frz);
    check("pause_ticks", n_tick, 0);
    check("pause_led_hold", n_led, 0);

    // Resume: prescaler restarts from 5, first TICK on 5th cycle
    press(1'b1, 1'b0, led7, led8, frz8, clr7, clr8);
    check("resume_led", led8, 1);
    window(12, first, n_tick, n_clr, n_led, n_frz);
    check("resume_first_tick", first, 4);

    // Bouncing SS then held low: exactly one state change (RUN -> PAUSE)
    changes  = 0;
    prev_led = sw_if.RUN_LED;
    for (int i = 0; i < 32; i++) begin
      if (i < 8)       sw_if.KEY_SS = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
      else if (i < 16) sw_if.KEY_SS = 1'b0;
      else             sw_if.KEY_SS = 1'b1;
      step();
      if (sw_if.RUN_LED != prev_led) changes++;
      prev_led = sw_if.RUN_LED;
    end
    check("bounce_changes", changes, 1);
    check("bounce_led", sw_if.RUN_LED, 0);

    // PAUSE -> RUN -> LAP
    press(1'b1, 1'b0, led7, led8, frz8, clr7, clr8);
    check("run2_led", led8, 1);
    window(10, first, n_tick, n_clr, n_led, n_frz);
    press(1'b0, 1'b1, led7, led8, frz8, clr7, clr8);
    check("lap_freeze", frz8, 1);
    check("lap_led", led8, 1);
    window(20, first, n_tick, n_clr, n_led, n_frz);
    check("lap_ticks20", n_tick, 2);
    check("lap_freeze_hold", n_frz, 20);

    // LAP -> RUN -> LAP -> PAUSE
    press(1'b0, 1'b1, led7, led8, frz8, clr7, clr8);
    check("unlap_freeze", frz8, 0);
    check("unlap_led", led8, 1);
    window(10, first, n_tick, n_clr, n_led, n_frz);
    check("unlap_ticks", n_tick, 1);
    press(1'b0, 1'b1, led7, led8, frz8, clr7, clr8);
    check("lap2_freeze", frz8, 1);
    window(10, first, n_tick, n_clr, n_led, n_frz);
    press(1'b1, 1'b0, led7, led8, frz8, clr7, clr8);
    check("lap_pause_freeze", frz8, 0);
    check("lap_pause_led", led8, 0);
    window(10, first, n_tick, n_clr, n_led, n_frz);
    check("lap_pause_ticks", n_tick, 0);

    // PAUSE -> IDLE with CLR for exactly one cycle
    press(1'b0, 1'b1, led7, led8, frz8, clr7, clr8);
    check("clear_clr_before", clr7, 0);
    check("clear_clr", clr8, 1);
    check("clear_led", led8, 0);
    window(10, first, n_tick, n_clr, n_led, n_frz);
    check("clear_clr_once", n_clr, 0);
    check("clear_idle_led", n_led, 0);

    // Both keys together in IDLE: SS wins, no CLR; prescaler was cleared
    press(1'b1, 1'b1, led7, led8, frz8, clr7, clr8);
    check("both_led", led8, 1);
    check("both_clr", clr8, 0);
    check("both_freeze", frz8, 0);
    window(12, first, n_tick, n_clr, n_led, n_frz);
    check("both_first_tick", first, 9);
    check("both_no_clr", n_clr, 0);

    // Reset while in LAP
    press(1'b0, 1'b1, led7, led8, frz8, clr7, clr8);
    check("lap3_freeze", frz8, 1);
    window(4, first, n_tick, n_clr, n_led, n_frz);
    RST = 1'b1;
    step();
    check("midrst_led", sw_if.RUN_LED, 0);
    check("midrst_freeze", sw_if.FREEZE, 0);
    check("midrst_clr", sw_if.CLR, 0);
    check("midrst_tick", sw_if.TICK, 0);
    RST = 1'b0;
    window(15, first, n_tick, n_clr, n_led, n_frz);
    check("postrst_ticks", n_tick, 0);
    check("postrst_clr", n_clr, 0);
    check("postrst_led", n_led, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
